// File: rtl/rxd_sampler_fsm.sv
// rxd_sampler_fsm: UART receive controller.
// Double-flop synchronises rxd, detects the start edge, samples each bit at
// mid-period using an oversampled tick, strobes bit_idx/bit_enb downstream and
// assembles the byte locally, reporting rdy / ferr / perr as 1-clk pulses.
// Optional feature macro: PARITY_CHECK_EN (even-parity bit between data and stop).
module rxd_sampler_fsm #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [2:0] bit_idx,
  output logic       bit_enb,
  output logic       rxd_s,
  output logic [7:0] data,
  output logic       rdy,
  output logic       ferr,
  output logic       perr
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TW      = $clog2(OVERSAMPLE + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] T_HALF   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_FULL   = TW'(OVERSAMPLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef PARITY_CHECK_EN
    S_PARITY,
`endif
    S_STOP,
    S_BRK
  } state_t;

  state_t        state_q;
  logic          sync1_q, sync2_q, prev_q;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_inc;
  logic [2:0]    bit_idx_q;
  logic          bit_enb_q;
  logic [7:0]    data_sh_q;
  logic [7:0]    data_q;
  logic          rdy_q, ferr_q;
  logic          tick, start_det;
`ifdef PARITY_CHECK_EN
  logic          par_q;
  logic          perr_q;
`endif

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Start-edge detect and free-running tick divider (restarted on start)
  always_comb begin
    start_det = (state_q == S_IDLE) && prev_q && !sync2_q;
    tick      = (div_cnt_q == DIV_LAST);
    tcnt_inc  = tcnt_q + TW'(1);
    div_cnt_d = div_cnt_q + DW'(1);
    if (start_det || tick) begin
      div_cnt_d = '0;
    end
  end

  // Divider count register
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // Receive FSM with registered outputs.
  // bit_enb is registered one clock after the sample point; bit_idx advances on
  // the clock after the strobe so that the pair stays aligned for the decoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tcnt_q    <= '0;
      bit_idx_q <= '0;
      bit_enb_q <= 1'b0;
      data_sh_q <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      bit_enb_q <= 1'b0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q    <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          tcnt_q    <= '0;
          bit_idx_q <= '0;
          if (start_det) begin
            state_q <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (tcnt_inc == T_HALF) begin
              tcnt_q <= '0;
              if (!sync2_q) begin
                state_q   <= S_DATA;
                bit_idx_q <= '0;
              end else begin
                state_q   <= S_IDLE;
                bit_idx_q <= '0;
              end
            end else begin
              tcnt_q <= tcnt_inc;
            end
          end
        end
        S_DATA: begin
          if (bit_enb_q && (bit_idx_q != 3'd7)) begin
            bit_idx_q <= bit_idx_q + 3'd1;
          end
          if (tick) begin
            if (tcnt_inc == T_FULL) begin
              tcnt_q               <= '0;
              bit_enb_q            <= 1'b1;
              data_sh_q[bit_idx_q] <= sync2_q;
              if (bit_idx_q == 3'd7) begin
`ifdef PARITY_CHECK_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end
            end else begin
              tcnt_q <= tcnt_inc;
            end
          end
        end
`ifdef PARITY_CHECK_EN
        S_PARITY: begin
          if (tick) begin
            if (tcnt_inc == T_FULL) begin
              tcnt_q  <= '0;
              par_q   <= sync2_q;
              state_q <= S_STOP;
            end else begin
              tcnt_q <= tcnt_inc;
            end
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (tcnt_inc == T_FULL) begin
              tcnt_q <= '0;
              if (sync2_q) begin
                state_q   <= S_IDLE;
                bit_idx_q <= '0;
`ifdef PARITY_CHECK_EN
                if ((^data_sh_q) == par_q) begin
                  data_q <= data_sh_q;
                  rdy_q  <= 1'b1;
                end else begin
                  perr_q <= 1'b1;
                end
`else
                data_q <= data_sh_q;
                rdy_q  <= 1'b1;
`endif
              end else begin
                ferr_q  <= 1'b1;
                state_q <= S_BRK;
              end
            end else begin
              tcnt_q <= tcnt_inc;
            end
          end
        end
        S_BRK: begin
          if (sync2_q) begin
            state_q   <= S_IDLE;
            bit_idx_q <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bit_idx = bit_idx_q;
  assign bit_enb = bit_enb_q;
  assign rxd_s   = sync2_q;
  assign data    = data_q;
  assign rdy     = rdy_q;
  assign ferr    = ferr_q;
`ifdef PARITY_CHECK_EN
  assign perr    = perr_q;
`else
  assign perr    = 1'b0;
`endif

endmodule
